// File: rtl/spi_master_tx_if.sv
// Word-side handshake plus SPI pins of the spi_master_tx initiator.
// modport master is the SPI initiator itself; modport slave is whatever surrounds it.
interface spi_master_tx_if;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        sclk;
    logic        mosi;
    logic        ss_n;
    logic        miso;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic [2:0]  dbg_state;

    modport master (
        input  tx_data, tx_valid, miso,
        output tx_ready, busy, sclk, mosi, ss_n, rx_data, rx_valid, dbg_state
    );

    modport slave (
        output tx_data, tx_valid, miso,
        input  tx_ready, busy, sclk, mosi, ss_n, rx_data, rx_valid, dbg_state
    );
endinterface

// File: rtl/spi_master_tx.sv
// SPI mode-0 initiator: shifts 32-bit words out MSB-first with a slowed sclk and a fixed ss_n frame.
// Define SPI_RX_CAPTURE_EN to also capture miso into rx_data at the end of each frame.
module spi_master_tx #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic           clock,
    input  logic           reset_n,
    spi_master_tx_if.master bus
);
    // tx_valid/tx_ready: a word transfers on any posedge where both are high; tx_ready is
    // high exactly while IDLE and never depends on tx_valid, so requests outside IDLE are dropped.
    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [31:0]      shreg_q, shreg_d;
    logic             sclk_q, sclk_d;
    logic             ss_n_q, ss_n_d;
    logic             div_end;

    assign div_end = (cnt_q == DIV_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            sclk_q    <= 1'b0;
            ss_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            sclk_q    <= sclk_d;
            ss_n_q    <= ss_n_d;
        end
    end

    // mosi is the top of the shift register, so clearing it at frame end returns mosi to 0.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        sclk_d    = sclk_q;
        ss_n_d    = ss_n_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.tx_valid) begin
                    state_d   = LEAD;
                    shreg_d   = bus.tx_data;
                    ss_n_d    = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            LEAD: begin
                if (div_end) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (div_end) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end else begin
                        sclk_d = 1'b0;
                        // The rising-edge count wraps to 0 only after the 32nd rise.
                        if (bit_cnt_q == 5'd0) begin
                            state_d = TRAIL;
                        end else begin
                            shreg_d = {shreg_q[30:0], 1'b0};
                        end
                    end
                end
            end
            TRAIL: begin
                if (div_end) begin
                    cnt_d   = '0;
                    state_d = GAP;
                    ss_n_d  = 1'b1;
                    shreg_d = '0;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tx_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sclk      = sclk_q;
    assign bus.ss_n      = ss_n_q;
    assign bus.mosi      = shreg_q[31];
    assign bus.dbg_state = state_q;

`ifdef SPI_RX_CAPTURE_EN
    logic [31:0] rx_shift_q, rx_shift_d;
    logic [31:0] rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // miso is taken on the same edge that launches sclk high, i.e. as the peer sees the rise.
    always_comb begin
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        if (state_q == SHIFT && div_end && !sclk_q) begin
            rx_shift_d = {rx_shift_q[30:0], bus.miso};
        end
        if (state_q == TRAIL && div_end) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
`else
    logic unused_miso;
    assign unused_miso  = bus.miso;
    assign bus.rx_data  = '0;
    assign bus.rx_valid = 1'b0;
`endif
endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: synchronised receiver model, miso peer, frame/timing scoreboard.
module tb_spi_master_tx;
  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 8;
  localparam int FRAME_LOW  = 66 * CLK_DIV;
  localparam int ACC_PERIOD = 1 + FRAME_LOW + GAP_CYCLES;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  spi_master_tx_if bus();

  spi_master_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  // clock / reset
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int done_frames = 0;
  logic [31:0] exp_q[$];
  logic [31:0] peer_word = 32'hCAFEF00D;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // raw pin monitor: per-frame ss_n low time, sclk rises, rx outputs at the first ss_n-high cycle
  logic prev_sclk = 1'b0, prev_ss = 1'b1;
  int low_cnt = 0, edge_cnt = 0, rxv_total = 0;
  int low_q[$], edge_q[$];
  logic rxv_q[$];
  logic [31:0] rxd_q[$];
  always @(negedge clock) begin
    if (bus.rx_valid) rxv_total++;
    if (!bus.ss_n) low_cnt++;
    if (bus.sclk && !prev_sclk) edge_cnt++;
    if (bus.ss_n && !prev_ss) begin
      low_q.push_back(low_cnt);
      edge_q.push_back(edge_cnt);
      rxv_q.push_back(bus.rx_valid);
      rxd_q.push_back(bus.rx_data);
      low_cnt = 0;
      edge_cnt = 0;
    end
    prev_sclk = bus.sclk;
    prev_ss = bus.ss_n;
  end

  // miso peer: presents the next bit of peer_word after each sclk fall
  int miso_idx = 0;
  logic p_sclk = 1'b0;
  always @(negedge clock) begin
    if (bus.ss_n) miso_idx = 0;
    else if (p_sclk && !bus.sclk) miso_idx++;
    p_sclk = bus.sclk;
    bus.miso = (!bus.ss_n && miso_idx < 32) ? peer_word[31 - miso_idx] : 1'b0;
  end

  // receiver model: 3-flop synchronisers, samples mosi on synchronised sclk rise
  logic [2:0] sy_sclk = '0, sy_mosi = '0, sy_ss = '1;
  logic [31:0] r_word = '0;
  int r_bits = 0;
  logic [31:0] rcv_q[$];
  int rbits_q[$];
  always @(negedge clock) begin
    if (sy_ss[2:1] == 2'b10) begin
      r_word = '0;
      r_bits = 0;
    end
    if (!sy_ss[1] && sy_sclk[2:1] == 2'b01) begin
      r_word = {r_word[30:0], sy_mosi[1]};
      r_bits++;
    end
    if (sy_ss[2:1] == 2'b01) begin
      rcv_q.push_back(r_word);
      rbits_q.push_back(r_bits);
    end
    sy_sclk = {sy_sclk[1:0], bus.sclk};
    sy_mosi = {sy_mosi[1:0], bus.mosi};
    sy_ss   = {sy_ss[1:0], bus.ss_n};
  end

  // driver tasks (called at a negedge)
  task automatic send(input logic [31:0] w, input bit hold, output int acc);
    int n;
    n = 0;
    acc = -1;
    bus.tx_data = w;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (bus.tx_ready) begin
      acc = cyc;
      exp_q.push_back(w);
    end else begin
      chk("accept_timeout", 32'(bus.tx_ready), 32'd1);
    end
    if (!hold) begin
      @(negedge clock);
      bus.tx_valid = 1'b0;
      bus.tx_data = $urandom;
    end
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (rcv_q.size() < n && t < 3000) begin
      @(negedge clock);
      t++;
    end
    if (rcv_q.size() < n) chk("frame_timeout", rcv_q.size(), n);
  endtask

  task automatic wait_edges(input int n);
    int t;
    t = 0;
    while (edge_cnt < n && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (edge_cnt < n) chk("edge_timeout", edge_cnt, n);
  endtask

  // scoreboard: one completed frame against the model
  task automatic check_frame(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    chk({tag, "_word"}, rcv_q.pop_front(), e);
    chk({tag, "_rbits"}, rbits_q.pop_front(), 32);
    chk({tag, "_edges"}, edge_q.pop_front(), 32);
    chk({tag, "_low"}, low_q.pop_front(), FRAME_LOW);
`ifdef SPI_RX_CAPTURE_EN
    chk({tag, "_rxv"}, 32'(rxv_q.pop_front()), 32'd1);
    chk({tag, "_rxd"}, rxd_q.pop_front(), peer_word);
`else
    chk({tag, "_rxv"}, 32'(rxv_q.pop_front()), 32'd0);
    chk({tag, "_rxd"}, rxd_q.pop_front(), 32'd0);
`endif
    done_frames++;
  endtask

  initial begin
    int a1, a2;
    logic [31:0] w;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    repeat (3) @(negedge clock);
    chk("rst_ss_n", 32'(bus.ss_n), 32'd1);
    chk("rst_sclk", 32'(bus.sclk), 32'd0);
    chk("rst_mosi", 32'(bus.mosi), 32'd0);
    chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rx_data", bus.rx_data, 32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // single frame; the peer shifts CAFEF00D back on miso
    send(32'hDEADBEEF, 1'b0, a1);
    wait_frames(1);
    check_frame("deadbeef");

    // back-to-back with tx_valid held
    peer_word = $urandom;
    send(32'h00000001, 1'b1, a1);
    @(negedge clock);
    send(32'h80000000, 1'b0, a2);
    chk("b2b_interval", a2 - a1, ACC_PERIOD);
    wait_frames(2);
    check_frame("b2b_first");
    check_frame("b2b_second");

    // request mid-frame is ignored
    w = $urandom;
    send(w, 1'b0, a1);
    wait_edges(12);
    chk("ign_busy_before", 32'(bus.busy), 32'd1);
    bus.tx_valid = 1'b1;
    bus.tx_data = 32'h12345678;
    @(negedge clock);
    chk("ign_busy_after", 32'(bus.busy), 32'd1);
    chk("ign_tx_ready", 32'(bus.tx_ready), 32'd0);
    bus.tx_valid = 1'b0;
    wait_frames(1);
    check_frame("ignored");
    repeat (700) @(negedge clock);
    chk("ign_no_extra_frame", low_q.size(), 0);
    chk("ign_idle_busy", 32'(bus.busy), 32'd0);

    // asynchronous reset mid-frame
    w = $urandom;
    send(w, 1'b0, a1);
    wait_edges(10);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ss_n", 32'(bus.ss_n), 32'd1);
    chk("mid_rst_sclk", 32'(bus.sclk), 32'd0);
    chk("mid_rst_mosi", 32'(bus.mosi), 32'd0);
    chk("mid_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    void'(exp_q.pop_front());
    repeat (10) @(negedge clock);
    rcv_q.delete();
    rbits_q.delete();
    low_q.delete();
    edge_q.delete();
    rxv_q.delete();
    rxd_q.delete();
    reset_n = 1'b1;
    @(negedge clock);
    send(32'hA5A5A5A5, 1'b0, a1);
    wait_frames(1);
    check_frame("after_reset");

    // randomized words, idle spacing and miso data
    for (int i = 0; i < 4; i++) begin
      peer_word = $urandom;
      w = $urandom;
      repeat ($urandom_range(0, 20)) @(negedge clock);
      send(w, 1'b0, a1);
      wait_frames(1);
      check_frame("rand");
    end

    repeat (20) @(negedge clock);
`ifdef SPI_RX_CAPTURE_EN
    chk("rx_valid_pulses", rxv_total, done_frames);
`else
    chk("rx_valid_pulses", rxv_total, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
